// File: rtl/popcnt_expand.sv
// popcnt_expand
//   Builds a WIDTH-bit mask holding exactly min(in_count, WIDTH) contiguous
//   ones starting at bit in_offset, wrapping modulo WIDTH. The mask is filled
//   CHUNK bits per cycle, so a request takes WIDTH/CHUNK cycles in BUSY.
//
// Ports
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   request handshake (in_ready high only in IDLE)
//   in_count              requested ones count, saturated to WIDTH
//   in_offset             bit index of the first one
//   out_valid / out_ready result handshake (out_valid high only in DONE)
//   out_mask              mask register (partial contents visible while BUSY)
//   out_count             count actually used after saturation
//   out_err               in_count exceeded WIDTH
module popcnt_expand #(
   parameter int unsigned WIDTH = 128,
   parameter int unsigned CHUNK = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [$clog2(WIDTH+1)-1:0]   in_count,
   input  logic [$clog2(WIDTH)-1:0]     in_offset,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [WIDTH-1:0]             out_mask,
   output logic [$clog2(WIDTH+1)-1:0]   out_count,
   output logic                         out_err
);

   localparam int unsigned CW  = $clog2(WIDTH + 1);
   localparam int unsigned OW  = $clog2(WIDTH);
   localparam int unsigned NCH = WIDTH / CHUNK;
   localparam int unsigned KW  = (NCH > 1) ? $clog2(NCH) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  mask_q,  mask_d;
   logic [CW-1:0]     cnt_q,   cnt_d;
   logic [OW-1:0]     off_q,   off_d;
   logic              err_q,   err_d;
   logic [KW-1:0]     k_q,     k_d;

   logic [OW-1:0]     base;
   logic [CHUNK-1:0]  chunk_bits;

   // Bit i is set when its distance above off, taken modulo WIDTH through
   // the natural wrap of an OW-bit subtraction, is below cnt.
   always_comb begin
      logic [OW-1:0] rel;
      base       = OW'(k_q * CHUNK);
      chunk_bits = '0;
      for (int unsigned j = 0; j < CHUNK; j++) begin
         rel           = (base + OW'(j)) - off_q;
         chunk_bits[j] = (CW'(rel) < cnt_q);
      end
   end

   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      cnt_d   = cnt_q;
      off_d   = off_q;
      err_d   = err_q;
      k_d     = k_q;
      unique case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               cnt_d   = (in_count > CW'(WIDTH)) ? CW'(WIDTH) : in_count;
               off_d   = in_offset;
               err_d   = (in_count > CW'(WIDTH));
               mask_d  = '0;
               k_d     = '0;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            mask_d[base +: CHUNK] = chunk_bits;
            k_d                   = k_q + KW'(1);
            if (k_q == KW'(NCH - 1)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         mask_q  <= '0;
         cnt_q   <= '0;
         off_q   <= '0;
         err_q   <= 1'b0;
         k_q     <= '0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         cnt_q   <= cnt_d;
         off_q   <= off_d;
         err_q   <= err_d;
         k_q     <= k_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign out_mask  = mask_q;
   assign out_count = cnt_q;
   assign out_err   = err_q;

endmodule

// File: tb/tb_popcnt_expand.sv
// Directed and randomized checks of popcnt_expand at WIDTH=128, CHUNK=8.
module tb_popcnt_expand;

   localparam int unsigned W = 128;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [7:0]   in_count = '0;
   logic [6:0]   in_offset = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [127:0] out_mask;
   logic [7:0]   out_count;
   logic         out_err;

   int checks = 0;
   int failures = 0;

   popcnt_expand #(.WIDTH(128), .CHUNK(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_count  (in_count),
      .in_offset (in_offset),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_mask  (out_mask),
      .out_count (out_count),
      .out_err   (out_err)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] ref_mask(input int unsigned cnt, input int unsigned off);
      logic [127:0] b;
      b = (cnt >= W) ? '1 : ((128'd1 << cnt) - 128'd1);
      if (off == 0) return b;
      return (b << off) | (b >> (W - off));
   endfunction

   // Present one request at a negedge and hold it across the accept edge.
   task automatic send(input logic [7:0] c, input logic [6:0] o);
      int unsigned w;
      w = 0;
      @(negedge clk);
      while (!in_ready && w < 200) begin
         @(negedge clk);
         w++;
      end
      check("send_in_ready", in_ready, 1);
      in_valid  = 1'b1;
      in_count  = c;
      in_offset = o;
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      in_count  = 8'($urandom);
      in_offset = 7'($urandom);
   endtask

   task automatic wait_done(output int unsigned lat);
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic release_out(input bit rnd);
      logic r;
      int unsigned tries;
      tries = 0;
      do begin
         @(negedge clk);
         r = (rnd && tries < 20) ? 1'($urandom_range(0, 1)) : 1'b1;
         out_ready = r;
         @(posedge clk);
         #1;
         tries++;
      end while (!r);
      check("post_hs_out_valid", out_valid, 0);
      check("post_hs_in_ready", in_ready, 1);
   endtask

   task automatic run_req(input string tag, input logic [7:0] c, input logic [6:0] o, input bit rnd);
      int unsigned lat;
      int unsigned sat;
      sat = (c > 8'd128) ? 128 : int'(c);
      send(c, o);
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      wait_done(lat);
      check({tag, "_latency"}, 128'(lat), 128'd16);
      check({tag, "_mask"}, out_mask, ref_mask(sat, int'(o)));
      check({tag, "_popcount"}, 128'($countones(out_mask)), 128'(sat));
      check({tag, "_count"}, 128'(out_count), 128'(sat));
      check({tag, "_err"}, 128'(out_err), 128'(c > 8'd128));
      release_out(rnd);
   endtask

   initial begin
      logic [127:0] hold_mask;
      logic [7:0]   hold_cnt;
      logic         hold_err;
      logic         stable;
      logic         busy_seen;
      int unsigned  lat;

      #12;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_mask", out_mask, 0);
      check("rst_out_count", 128'(out_count), 0);
      check("rst_out_err", 128'(out_err), 0);
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;

      run_req("c5_o0", 8'd5, 7'd0, 1'b0);
      check("c5_o0_literal", ref_mask(5, 0), 128'h1F);
      run_req("c10_o124", 8'd10, 7'd124, 1'b0);
      check("c10_o124_literal", ref_mask(10, 124), 128'hF000_0000_0000_0000_0000_0000_0000_003F);
      run_req("c0_o33", 8'd0, 7'd33, 1'b0);
      run_req("c128_o77", 8'd128, 7'd77, 1'b0);
      run_req("c200_o5", 8'd200, 7'd5, 1'b0);
      run_req("c255_o127", 8'd255, 7'd127, 1'b0);
      run_req("c129_o0", 8'd129, 7'd0, 1'b0);
      run_req("c127_o1", 8'd127, 7'd1, 1'b0);
      run_req("c1_o127", 8'd1, 7'd127, 1'b0);

      // Backpressure: hold DONE for 40 cycles while a competing request waits.
      out_ready = 1'b0;
      send(8'd20, 7'd100);
      wait_done(lat);
      check("bp_latency", 128'(lat), 128'd16);
      check("bp_mask", out_mask, ref_mask(20, 100));
      hold_mask = out_mask;
      hold_cnt  = out_count;
      hold_err  = out_err;
      stable    = 1'b1;
      busy_seen = 1'b0;
      @(negedge clk);
      in_valid  = 1'b1;
      in_count  = 8'd3;
      in_offset = 7'd9;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (out_mask !== hold_mask || out_count !== hold_cnt || out_err !== hold_err || out_valid !== 1'b1)
            stable = 1'b0;
         if (in_ready !== 1'b0) busy_seen = 1'b1;
      end
      check("bp_outputs_stable", 128'(stable), 1);
      check("bp_in_ready_low", 128'(busy_seen), 0);
      @(negedge clk);
      in_valid = 1'b0;
      release_out(1'b0);
      check("bp_mask_after_hs", out_mask, ref_mask(20, 100));
      @(posedge clk);
      #1;
      check("bp_no_accept", in_ready, 1);
      out_ready = 1'b1;

      // Reset in the middle of BUSY after chunk 6 is written, while k=7.
      send(8'd128, 7'd0);
      repeat (7) @(posedge clk);
      #1;
      check("mid_partial_mask", out_mask, (128'd1 << 56) - 128'd1);
      check("mid_busy_in_ready", in_ready, 0);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_in_ready", in_ready, 1);
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_mask", out_mask, 0);
      check("mid_rst_count", 128'(out_count), 0);
      check("mid_rst_err", 128'(out_err), 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_req("after_rst_c3", 8'd3, 7'd0, 1'b0);
      check("after_rst_literal", ref_mask(3, 0), 128'h7);

      for (int n = 0; n < 1000; n++) begin
         run_req("sweep", 8'($urandom_range(0, 255)), 7'($urandom_range(0, 127)), 1'b1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/popcnt_expand.md
# popcnt_expand

Inverse companion of the population-count spec: accepts a ones-count `N` and a start offset, and produces a `WIDTH`-bit mask containing exactly `N` contiguous ones beginning at that offset, wrapping modulo `WIDTH`. The mask is built sequentially, `CHUNK` bits per cycle, behind valid/ready handshakes on both sides. The popcount cosim uses it as a stimulus generator: its output feeds the popcount spec, and the bench requires that spec output equals the accepted (saturated) count.

## Interface
- `WIDTH`, 128 — mask width; power of two, ≥ `CHUNK`.
- `CHUNK`, 8 — bits filled per BUSY cycle; power of two dividing `WIDTH`.
- `clk` in 1 — clock, rising-edge.
- `rst_n` in 1 — asynchronous active-low reset.
- `in_valid` in 1 — request valid.
- `in_ready` out 1 — block can accept; high only in IDLE.
- `in_count` in $clog2(WIDTH+1) (8) — requested ones count, 0..255.
- `in_offset` in $clog2(WIDTH) (7) — bit index of first one.
- `out_valid` out 1 — mask valid; high only in DONE.
- `out_ready` in 1 — consumer accepts mask.
- `out_mask` out `WIDTH` — generated mask.
- `out_count` out 8 — count actually used, after saturation.
- `out_err` out 1 — set when `in_count` > `WIDTH`.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: `in_ready`=1. When `in_valid && in_ready` at a rising edge:
  - latch `cnt = min(in_count, WIDTH)`, `off = in_offset`, `err = (in_count > WIDTH)`;
  - clear the mask register and the chunk index `k`;
  - go to BUSY.
- BUSY: each edge writes chunk `k`, bits `[k*CHUNK +: CHUNK]`. Bit `i` is 1 iff `((i - off) mod WIDTH) < cnt`. Compute the subtraction in `$clog2(WIDTH)` bits so it wraps naturally. The comparison is unsigned, with `cnt` at 8 bits.
  - `k` increments by one per edge.
  - After the edge that writes chunk `WIDTH/CHUNK-1`, go to DONE.
- DONE: `out_valid`=1. `out_mask`, `out_count` and `out_err` hold stable until `out_valid && out_ready`, then go to IDLE.
- `out_mask` always drives the internal register, including partial contents during BUSY. Consumers sample it only while `out_valid`=1.
- Boundary cases:
  - `cnt`=0 gives an all-zero mask.
  - `cnt`=`WIDTH` gives all ones regardless of `off`.
  - `off + cnt > WIDTH` wraps into low bits.
  - `in_count` of 129..255 saturates to 128 with `out_err`=1.
- `in_ready` is 0 in BUSY and DONE. No input pipelining and no DONE→IDLE bypass: a new request cannot be accepted on the same edge as the output handshake.
- Reset, asserted at any time including mid-BUSY or DONE:
  - state becomes IDLE immediately;
  - all registers clear: mask = 0, `out_count` = 0, `out_err` = 0, `k` = 0;
  - the in-flight request is dropped.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_mask`=0, `out_count`=0, `out_err`=0.
- Outputs are registered or decoded from state only; no combinational path from input ports to outputs.
- Latency: accept at edge E0, so `out_valid` rises after edge E(`WIDTH/CHUNK`), i.e. E16 at defaults.
- With `out_ready` held high, throughput is one request per `WIDTH/CHUNK+2` cycles (18 at defaults): BUSY ×16, DONE ×1, IDLE ×1.
- `out_ready` may be low for arbitrarily long; DONE outputs must not change meanwhile.
- Inputs are ignored outside the IDLE handshake edge. Changing `in_count` during BUSY has no effect.

## Test plan
- Reset, then `in_count`=5, `in_offset`=0, `out_ready`=1:
  - `out_valid` high exactly 16 cycles after accept;
  - `out_mask`=128'h1F, `out_count`=5, `out_err`=0;
  - popcount spec output = 5.
- `in_count`=10, `in_offset`=124: `out_mask` bits 124..127 and 0..5 set (128'hF000…003F), popcount 10.
- Edge counts:
  - `in_count`=0 with any offset → mask 0;
  - `in_count`=128, `in_offset`=77 → all ones;
  - `in_count`=200 → all ones, `out_count`=128, `out_err`=1.
- Backpressure:
  - hold `out_ready`=0 for 40 cycles in DONE; outputs stay stable and `in_ready` stays 0;
  - a request presented meanwhile is not accepted;
  - after the handshake, `in_ready`=1 on the next cycle.
- Reset mid-operation: assert `rst_n`=0 during BUSY chunk 7; all outputs return to reset values asynchronously. After release, a fresh `in_count`=3 request yields 128'h7.
- Random sweep of 1000 requests (count 0..255, random offset, random `out_ready`): popcount of the mask = `min(count, 128)`, and the mask equals its reference rotation `(2^cnt-1) << off mod 128`.
